// File: rtl/usb_setup_pkt_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_setup_pkt_collector_if
// Description : EP0 SETUP payload bus between the packet receiver/consumer and
//               the SETUP packet collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_setup_pkt_collector_if;
    logic        setupStart;
    logic [7:0]  rxByte;
    logic        rxByteValid;
    logic        rxPktEnd;
    logic        rxPktErr;
    logic [63:0] setupPkt;
    logic        setupValid;
    logic        setupReady;
    logic        setupDevToHost;
    logic        setupHasData;
    logic        setupAck;
    logic        setupDiscard;

    modport master (
        output setupStart, rxByte, rxByteValid, rxPktEnd, rxPktErr, setupReady,
        input  setupPkt, setupValid, setupDevToHost, setupHasData, setupAck, setupDiscard
    );

    modport slave (
        input  setupStart, rxByte, rxByteValid, rxPktEnd, rxPktErr, setupReady,
        output setupPkt, setupValid, setupDevToHost, setupHasData, setupAck, setupDiscard
    );
endinterface
`default_nettype wire

// File: rtl/usb_setup_pkt_collector.sv
`default_nettype none
// ============================================================================
// Module      : usb_setup_pkt_collector
// Description : Assembles and validates the 8-byte SETUP DATA0 payload on EP0.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_setup_pkt_collector #(
    parameter int RX_TIMEOUT = 64
) (
    input  wire logic               clk48,
    input  wire logic               rst,
    usb_setup_pkt_collector_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam int                  c_tmr_w    = (RX_TIMEOUT < 2) ? 1 : $clog2(RX_TIMEOUT + 1);
    localparam bit                  c_tmr_en   = (RX_TIMEOUT > 0);
    localparam logic [c_tmr_w-1:0]  c_tmr_last = c_tmr_en ? c_tmr_w'(RX_TIMEOUT - 1) : '0;

    state_t               r_state;
    logic [3:0]           r_count;
    logic [c_tmr_w-1:0]   r_timer;
    logic                 r_err;
    logic [63:0]          r_shadow;
    logic [63:0]          r_pkt;
    logic                 r_valid;
    logic                 r_ack;
    logic                 r_discard;

    logic [63:0]          w_shadow;
    logic [3:0]           w_count;
    logic                 w_err;
    logic                 w_timeout;

    // Wire order is little-endian per 16-bit field; map byte index to its lane.
    function automatic logic [5:0] lane_lsb(input logic [2:0] idx);
        case (idx)
            3'd0:    lane_lsb = 6'd56;
            3'd1:    lane_lsb = 6'd48;
            3'd2:    lane_lsb = 6'd32;
            3'd3:    lane_lsb = 6'd40;
            3'd4:    lane_lsb = 6'd16;
            3'd5:    lane_lsb = 6'd24;
            3'd6:    lane_lsb = 6'd0;
            default: lane_lsb = 6'd8;
        endcase
    endfunction

    // Effective byte count/shadow include a byte arriving with rxPktEnd.
    always_comb begin
        w_shadow = r_shadow;
        w_count  = r_count;
        if (bus.rxByteValid) begin
            if (r_count < 4'd8) begin
                w_shadow[lane_lsb(r_count[2:0]) +: 8] = bus.rxByte;
                w_count = r_count + 4'd1;
            end else begin
                w_count = 4'd9;
            end
        end
        w_err     = r_err | bus.rxPktErr;
        w_timeout = c_tmr_en && !bus.rxByteValid && (r_timer == c_tmr_last);
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= 4'd0;
            r_timer   <= '0;
            r_err     <= 1'b0;
            r_shadow  <= 64'd0;
            r_pkt     <= 64'd0;
            r_valid   <= 1'b0;
            r_ack     <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_ack     <= 1'b0;
            r_discard <= 1'b0;
            if (bus.setupStart) begin
                // A new SETUP always wins and silently drops anything in flight.
                r_state <= ST_COLLECT;
                r_count <= 4'd0;
                r_timer <= '0;
                r_err   <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_COLLECT: begin
                        r_shadow <= w_shadow;
                        r_count  <= w_count;
                        r_err    <= w_err;
                        r_timer  <= bus.rxByteValid ? '0 : r_timer + c_tmr_w'(1);
                        if (bus.rxPktEnd) begin
                            if (w_count == 4'd8 && !w_err) begin
                                r_pkt   <= w_shadow;
                                r_valid <= 1'b1;
                                r_ack   <= 1'b1;
                                r_state <= ST_HOLD;
                            end else begin
                                r_discard <= 1'b1;
                                r_state   <= ST_IDLE;
                            end
                        end else if (w_timeout) begin
                            r_discard <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (bus.setupReady) begin
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.setupPkt       = r_pkt;
    assign bus.setupValid     = r_valid;
    assign bus.setupAck       = r_ack;
    assign bus.setupDiscard   = r_discard;
    assign bus.setupDevToHost = r_pkt[63];
    assign bus.setupHasData   = |r_pkt[15:0];

endmodule
`default_nettype wire

// File: tb/tb_usb_setup_pkt_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_setup_pkt_collector
// Description : Directed self-checking bench for usb_setup_pkt_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_setup_pkt_collector;

    logic clk48 = 1'b0;
    logic rst   = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    localparam logic [63:0] c_get_desc_wire = 64'h8006_0001_0000_1200;
    localparam logic [63:0] c_get_desc_pkt  = 64'h8006_0100_0000_0012;
    localparam logic [63:0] c_set_addr_wire = 64'h0005_0500_0000_0000;
    localparam logic [63:0] c_set_addr_pkt  = 64'h0005_0005_0000_0000;

    usb_setup_pkt_collector_if bus();

    usb_setup_pkt_collector #(.RX_TIMEOUT(64)) dut (
        .clk48 (clk48),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk48 = ~clk48;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        bus.setupStart = 1'b1;
        tick();
        bus.setupStart = 1'b0;
    endtask

    task automatic end_pulse();
        bus.rxPktEnd = 1'b1;
        tick();
        bus.rxPktEnd = 1'b0;
    endtask

    // Sends wire bytes first..last (index 0 at b[63:56]); last may carry rxPktEnd.
    task automatic send(input logic [63:0] b, input int first, input int last, input bit end_last);
        for (int i = first; i <= last; i++) begin
            bus.rxByte      = b[63 - 8 * (i % 8) -: 8];
            bus.rxByteValid = 1'b1;
            bus.rxPktEnd    = end_last && (i == last);
            tick();
        end
        bus.rxByteValid = 1'b0;
        bus.rxPktEnd    = 1'b0;
    endtask

    initial begin
        bus.setupStart  = 1'b0;
        bus.rxByte      = 8'h00;
        bus.rxByteValid = 1'b0;
        bus.rxPktEnd    = 1'b0;
        bus.rxPktErr    = 1'b0;
        bus.setupReady  = 1'b0;
        tick();
        tick();
        chk("reset_pkt",     bus.setupPkt, 64'd0);
        chk("reset_valid",   64'(bus.setupValid), 64'd0);
        chk("reset_ack",     64'(bus.setupAck), 64'd0);
        chk("reset_discard", 64'(bus.setupDiscard), 64'd0);
        chk("reset_d2h",     64'(bus.setupDevToHost), 64'd0);
        chk("reset_hasdata", 64'(bus.setupHasData), 64'd0);
        rst = 1'b0;
        tick();

        // GET_DESCRIPTOR, held for 10 cycles without ready
        start_pulse();
        send(c_get_desc_wire, 0, 7, 1'b1);
        chk("gd_valid",   64'(bus.setupValid), 64'd1);
        chk("gd_pkt",     bus.setupPkt, c_get_desc_pkt);
        chk("gd_d2h",     64'(bus.setupDevToHost), 64'd1);
        chk("gd_hasdata", 64'(bus.setupHasData), 64'd1);
        chk("gd_ack",     64'(bus.setupAck), 64'd1);
        chk("gd_discard", 64'(bus.setupDiscard), 64'd0);
        tick();
        chk("gd_ack_pulse", 64'(bus.setupAck), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("gd_held", 64'(bus.setupValid), 64'd1);
        bus.setupReady = 1'b1;
        tick();
        bus.setupReady = 1'b0;
        chk("gd_consumed", 64'(bus.setupValid), 64'd0);

        // SET_ADDRESS
        start_pulse();
        send(c_set_addr_wire, 0, 7, 1'b1);
        chk("sa_pkt",     bus.setupPkt, c_set_addr_pkt);
        chk("sa_d2h",     64'(bus.setupDevToHost), 64'd0);
        chk("sa_hasdata", 64'(bus.setupHasData), 64'd0);
        chk("sa_ack",     64'(bus.setupAck), 64'd1);
        bus.setupReady = 1'b1;
        tick();
        bus.setupReady = 1'b0;
        chk("sa_consumed", 64'(bus.setupValid), 64'd0);

        // Short packet: 7 bytes then separate EOP
        start_pulse();
        send(c_get_desc_wire, 0, 6, 1'b0);
        end_pulse();
        chk("short_discard", 64'(bus.setupDiscard), 64'd1);
        chk("short_ack",     64'(bus.setupAck), 64'd0);
        chk("short_valid",   64'(bus.setupValid), 64'd0);
        chk("short_pkt",     bus.setupPkt, c_set_addr_pkt);
        tick();
        chk("short_disc_pulse", 64'(bus.setupDiscard), 64'd0);

        // Long packet: 9 bytes, EOP with the 9th
        start_pulse();
        send(c_get_desc_wire, 0, 8, 1'b1);
        chk("long_discard", 64'(bus.setupDiscard), 64'd1);
        chk("long_valid",   64'(bus.setupValid), 64'd0);
        chk("long_ack",     64'(bus.setupAck), 64'd0);

        // Zero-length packet
        start_pulse();
        end_pulse();
        chk("zlp_discard", 64'(bus.setupDiscard), 64'd1);
        chk("zlp_valid",   64'(bus.setupValid), 64'd0);

        // rxPktErr after byte 3, full 8 bytes, acted on at EOP
        start_pulse();
        send(c_get_desc_wire, 0, 2, 1'b0);
        bus.rxPktErr = 1'b1;
        tick();
        bus.rxPktErr = 1'b0;
        chk("err_deferred", 64'(bus.setupDiscard), 64'd0);
        send(c_get_desc_wire, 3, 7, 1'b1);
        chk("err_discard", 64'(bus.setupDiscard), 64'd1);
        chk("err_ack",     64'(bus.setupAck), 64'd0);
        chk("err_valid",   64'(bus.setupValid), 64'd0);
        chk("err_pkt",     bus.setupPkt, c_set_addr_pkt);

        // Timeout: 4 bytes then a 64-cycle gap
        start_pulse();
        send(c_get_desc_wire, 0, 3, 1'b0);
        for (int i = 0; i < 63; i++) tick();
        chk("tmo_not_yet", 64'(bus.setupDiscard), 64'd0);
        tick();
        chk("tmo_discard", 64'(bus.setupDiscard), 64'd1);
        chk("tmo_ack",     64'(bus.setupAck), 64'd0);
        send(c_get_desc_wire, 0, 7, 1'b1);
        chk("tmo_ignored_valid",   64'(bus.setupValid), 64'd0);
        chk("tmo_ignored_ack",     64'(bus.setupAck), 64'd0);
        chk("tmo_ignored_discard", 64'(bus.setupDiscard), 64'd0);
        chk("tmo_pkt",             bus.setupPkt, c_set_addr_pkt);

        // Supersede: A in HOLD, new SETUP, then B
        start_pulse();
        send(c_get_desc_wire, 0, 7, 1'b1);
        chk("sup_a_valid", 64'(bus.setupValid), 64'd1);
        tick();
        start_pulse();
        chk("sup_drop", 64'(bus.setupValid), 64'd0);
        send(c_set_addr_wire, 0, 7, 1'b1);
        chk("sup_b_valid", 64'(bus.setupValid), 64'd1);
        chk("sup_b_pkt",   bus.setupPkt, c_set_addr_pkt);

        // setupStart together with setupReady and with EOP of the old packet
        bus.setupReady = 1'b1;
        bus.setupStart = 1'b1;
        tick();
        bus.setupReady = 1'b0;
        bus.setupStart = 1'b0;
        chk("ready_start_valid", 64'(bus.setupValid), 64'd0);
        send(c_get_desc_wire, 0, 6, 1'b0);
        bus.rxByte      = 8'h00;
        bus.rxByteValid = 1'b1;
        bus.rxPktEnd    = 1'b1;
        bus.setupStart  = 1'b1;
        tick();
        bus.rxByteValid = 1'b0;
        bus.rxPktEnd    = 1'b0;
        bus.setupStart  = 1'b0;
        chk("start_eop_ack",     64'(bus.setupAck), 64'd0);
        chk("start_eop_discard", 64'(bus.setupDiscard), 64'd0);
        chk("start_eop_valid",   64'(bus.setupValid), 64'd0);
        send(c_get_desc_wire, 0, 7, 1'b1);
        chk("start_eop_new_pkt", bus.setupPkt, c_get_desc_pkt);
        chk("start_eop_new_ack", 64'(bus.setupAck), 64'd1);

        // Async reset mid-COLLECT
        tick();
        start_pulse();
        send(c_set_addr_wire, 0, 2, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_pkt",   bus.setupPkt, 64'd0);
        chk("arst_valid", 64'(bus.setupValid), 64'd0);
        chk("arst_d2h",   64'(bus.setupDevToHost), 64'd0);
        #1 rst = 1'b0;
        send(c_set_addr_wire, 3, 7, 1'b1);
        chk("arst_no_ack",   64'(bus.setupAck), 64'd0);
        chk("arst_no_valid", 64'(bus.setupValid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
